// File: rtl/pe_accum_2x2.sv
// pe_accum_2x2: sums the four signed PE products of each accepted beat, accumulates KLEN
// beats into one signed result and queues results in a show-ahead FIFO drained by
// valid/ready. The PE feeder is backpressured while the FIFO is full.
// Optional feature macro: PE_ACC_SAT_EN (saturating accumulation with a sticky sat flag);
// when undefined, arithmetic wraps and sat is tied low.
module pe_accum_2x2 #(
   parameter int unsigned BITS     = 8,
   parameter int unsigned ACC_BITS = 24,
   parameter int unsigned KLEN     = 9,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [2*BITS-1:0]   pe_out0,
   input  logic signed [2*BITS-1:0]   pe_out1,
   input  logic signed [2*BITS-1:0]   pe_out2,
   input  logic signed [2*BITS-1:0]   pe_out3,
   output logic signed [ACC_BITS-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       sat
);

   localparam int unsigned PW = 2 * BITS;
   localparam int unsigned SW = PW + 2;
   localparam int unsigned CW = (KLEN > 1) ? $clog2(KLEN) : 1;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(KLEN - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic {StIdle, StAccum} state_e;

   state_e                state_q, state_d;
   logic [ACC_BITS-1:0]   acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ACC_BITS-1:0]   mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q, count_d;
   logic [SW-1:0]         sum4;
   logic [ACC_BITS-1:0]   acc_sum;
   logic                  accept, push, pop, full, empty;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign accept   = en && in_valid && in_ready && !clear;
   assign pop      = !empty && out_ready;
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign busy      = (state_q == StAccum);

   // Sign-extend each product by two bits so the four-way sum cannot overflow.
   always_comb begin
      sum4 = {{2{pe_out0[PW-1]}}, pe_out0} + {{2{pe_out1[PW-1]}}, pe_out1}
           + {{2{pe_out2[PW-1]}}, pe_out2} + {{2{pe_out3[PW-1]}}, pe_out3};
   end

`ifdef PE_ACC_SAT_EN
   logic [ACC_BITS:0] wide;
   logic              clamp;
   logic              sat_q;

   // One guard bit detects overflow; clamp to the nearest representable extreme.
   always_comb begin
      wide    = {acc_q[ACC_BITS-1], acc_q} + {{(ACC_BITS + 1 - SW){sum4[SW-1]}}, sum4};
      clamp   = 1'b0;
      acc_sum = wide[ACC_BITS-1:0];
      if (wide[ACC_BITS] != wide[ACC_BITS-1]) begin
         clamp   = 1'b1;
         acc_sum = wide[ACC_BITS] ? {1'b1, {(ACC_BITS - 1){1'b0}}}
                                  : {1'b0, {(ACC_BITS - 1){1'b1}}};
      end
   end

   // Sticky saturation flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_q <= 1'b0;
      else if (accept && clamp) sat_q <= 1'b1;
   end

   assign sat = sat_q;
`else
   // Plain modulo-2^ACC_BITS accumulation.
   always_comb begin
      acc_sum = acc_q + {{(ACC_BITS - SW){sum4[SW-1]}}, sum4};
   end

   assign sat = 1'b0;
`endif

   // Window next-state: clear aborts and wins over a beat; the last beat pushes the result.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      if (clear) begin
         state_d = StIdle;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         if (cnt_q == LAST_CNT) begin
            push    = 1'b1;
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            state_d = StAccum;
            acc_d   = acc_sum;
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   // Window state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // FIFO occupancy; push never coincides with full because in_ready gates accept.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are don't-care while unoccupied, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= acc_sum;
   end

endmodule

// File: tb/tb_pe_accum_2x2.sv
// Directed self-checking bench for pe_accum_2x2 (default build and an ACC_BITS=20 instance).
module tb_pe_accum_2x2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               en = 1'b1;
   logic               clear = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b1;
   logic signed [15:0] pe_out0 = '0, pe_out1 = '0, pe_out2 = '0, pe_out3 = '0;

   logic               in_ready, out_valid, busy, sat;
   logic signed [23:0] out_data;
   logic               in_ready20, out_valid20, busy20, sat20;
   logic signed [19:0] out_data20;

   int n_checks = 0;
   int n_fail   = 0;
   int got [$];

   always #5 clk = ~clk;

   pe_accum_2x2 u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .pe_out0(pe_out0), .pe_out1(pe_out1), .pe_out2(pe_out2),
      .pe_out3(pe_out3), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .sat(sat)
   );

   pe_accum_2x2 #(.ACC_BITS(20)) u_dut20 (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready20), .pe_out0(pe_out0), .pe_out1(pe_out1), .pe_out2(pe_out2),
      .pe_out3(pe_out3), .out_data(out_data20), .out_valid(out_valid20),
      .out_ready(out_ready), .busy(busy20), .sat(sat20)
   );

   task automatic set_pe(input int v);
      pe_out0 = 16'(v);
      pe_out1 = 16'(v);
      pe_out2 = 16'(v);
      pe_out3 = 16'(v);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      clear    = 1'b0;
      en       = 1'b1;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Present one beat and hold it until an edge where in_ready was high.
   task automatic send_beat(input int v);
      int waited;
      set_pe(v);
      in_valid = 1'b1;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_beat_timeout: in_ready got %b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_window(input int v, input int n);
      for (int i = 0; i < n; i++) send_beat(v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_checks++; if (out_data !== 24'sd0) begin n_fail++;
         $display("FAIL reset_out_data: got %0d required 0", out_data); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (sat !== 1'b0) begin n_fail++;
         $display("FAIL reset_sat: got %b required 0", sat); end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      send_beat(10);
      n_checks++; if (busy !== 1'b1) begin n_fail++;
         $display("FAIL basic_busy_first: got %b required 1", busy); end
      send_window(10, 7);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL basic_early_valid: got %b required 0", out_valid); end
      send_beat(10);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++;
         $display("FAIL basic_valid: got %b required 1", out_valid); end
      n_checks++; if (out_data !== 24'sd360) begin n_fail++;
         $display("FAIL basic_data: got %0d required 360", out_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL basic_busy_done: got %b required 0", busy); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL basic_popped: got %b required 0", out_valid); end
   endtask

   task automatic test_negative();
      int exp20;
      logic exp_sat20;
`ifdef PE_ACC_SAT_EN
      exp20 = -524288;
      exp_sat20 = 1'b1;
`else
      exp20 = 463360;
      exp_sat20 = 1'b0;
`endif
      do_reset();
      out_ready = 1'b1;
      send_window(-16256, 9);
      n_checks++; if (out_data !== -24'sd585216) begin n_fail++;
         $display("FAIL neg_data: got %0d required -585216", out_data); end
      n_checks++; if (sat !== 1'b0) begin n_fail++;
         $display("FAIL neg_sat: got %b required 0", sat); end
      n_checks++; if (out_data20 !== 20'(exp20)) begin n_fail++;
         $display("FAIL neg20_data: got %0d required %0d", out_data20, exp20); end
      n_checks++; if (sat20 !== exp_sat20) begin n_fail++;
         $display("FAIL neg20_sat: got %b required %b", sat20, exp_sat20); end
   endtask

   task automatic test_fifo_full();
      int cyc;
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_window(k, 9);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++;
         $display("FAIL full_in_ready: got %b required 0", in_ready); end
      // Window 5 beat presented against a full FIFO must not be taken.
      set_pe(5);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++;
         $display("FAIL full_hold: in_ready/busy got %b/%b required 0/0", in_ready, busy); end
      n_checks++; if (out_data !== 24'sd36) begin n_fail++;
         $display("FAIL full_head: got %0d required 36", out_data); end
      out_ready = 1'b1;
      got.delete();
      fork
         send_window(5, 9);
         begin
            cyc = 0;
            while (got.size() < 5 && cyc < 60) begin
               if (out_valid) got.push_back(int'(out_data));
               @(posedge clk);
               #1;
               cyc++;
               if (cyc == 1) begin
                  n_checks++; if (in_ready !== 1'b1) begin n_fail++;
                     $display("FAIL full_ready_rise: got %b required 1", in_ready); end
               end
            end
         end
      join
      n_checks++; if (got.size() != 5) begin n_fail++;
         $display("FAIL full_count: got %0d results required 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_checks++; if (got[i] != 36 * (i + 1)) begin n_fail++;
            $display("FAIL full_order[%0d]: got %0d required %0d", i, got[i], 36 * (i + 1)); end
      end
   endtask

   task automatic test_clear();
      do_reset();
      out_ready = 1'b1;
      send_window(7, 4);
      set_pe(100);
      in_valid = 1'b1;
      clear    = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL clear_abort: busy/out_valid got %b/%b required 0/0", busy, out_valid); end
      send_window(10, 9);
      n_checks++; if (out_data !== 24'sd360 || out_valid !== 1'b1) begin n_fail++;
         $display("FAIL clear_result: got %0d valid %b required 360 valid 1", out_data, out_valid); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL clear_single: got %b required 0", out_valid); end
   endtask

   task automatic test_enable();
      do_reset();
      out_ready = 1'b1;
      en = 1'b0;
      set_pe(50);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL en_hold: busy got %b required 0", busy); end
      en = 1'b1;
      send_window(10, 9);
      n_checks++; if (out_data !== 24'sd360) begin n_fail++;
         $display("FAIL en_result: got %0d required 360", out_data); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      send_window(1, 9);
      send_window(2, 9);
      send_window(10, 3);
      n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++;
         $display("FAIL mid_setup: out_valid/busy got %b/%b required 1/1", out_valid, busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL mid_out_valid: got %b required 0", out_valid); end
      n_checks++; if (out_data !== 24'sd0) begin n_fail++;
         $display("FAIL mid_out_data: got %0d required 0", out_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL mid_busy: got %b required 0", busy); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_window(3, 9);
      n_checks++; if (out_data !== 24'sd108 || out_valid !== 1'b1) begin n_fail++;
         $display("FAIL mid_clean: got %0d valid %b required 108 valid 1", out_data, out_valid); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL mid_only_own: got %b required 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_fifo_full();
      test_clear();
      test_enable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
